// File: rtl/hm01b0_pixel_source_if.sv
// HM01B0-style parallel pixel bus.
//   pixclk   free-running pixel clock
//   vsync    frame valid
//   hsync    line valid
//   pixdata  pixel value, meaningful while vsync & hsync
// master = transmitter (pixel source), slave = receiver.
interface hm01b0_pixel_source_if;
  logic       pixclk;
  logic       vsync;
  logic       hsync;
  logic [7:0] pixdata;

  modport master (output pixclk, vsync, hsync, pixdata);
  modport slave  (input  pixclk, vsync, hsync, pixdata);
endinterface

// File: rtl/hm01b0_pixel_source.sv
// HM01B0 parallel pixel-bus emulator. Generates test-pattern frames on the
// same bus the frame/pixel-count receiver consumes, so capture and reporting
// can run on the board without the sensor fitted.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low
//   enable       1 = emit frames; 0 = stop once the current frame completes
//   pattern      0 ramp x, 1 frame count, 2 checker (x[3]^y[3]), 3 x+y
//   bus          pixel bus (pixclk, vsync, hsync, pixdata), master side
//   frame_count  completed frames, wraps at 0xFFFF
//   frame_done   1-clk pulse when a frame completes
//   busy         1 whenever the generator is not idle
module hm01b0_pixel_source #(
  parameter int unsigned H_ACTIVE = 324,
  parameter int unsigned V_ACTIVE = 244,
  parameter int unsigned H_BLANK  = 16,
  parameter int unsigned V_LEAD   = 8,
  parameter int unsigned V_TAIL   = 8,
  parameter int unsigned F_GAP    = 64,
  parameter int unsigned CLK_DIV  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [1:0]                    pattern,
  hm01b0_pixel_source_if.master         bus,
  output logic [15:0]                   frame_count,
  output logic                          frame_done,
  output logic                          busy
);

  localparam logic [15:0] H_LAST   = 16'(H_ACTIVE - 1);
  localparam logic [15:0] V_LAST   = 16'(V_ACTIVE - 1);
  localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
  localparam logic [15:0] LD_LAST  = 16'(V_LEAD - 1);
  localparam logic [15:0] TL_LAST  = 16'(V_TAIL - 1);
  localparam logic [15:0] GP_LAST  = 16'(F_GAP - 1);
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_LINE,
    S_HBLANK,
    S_TAIL,
    S_GAP
  } state_t;

  state_t      state_reg;
  logic [15:0] div_reg;
  logic        pixclk_reg;
  logic [15:0] slot_cnt_reg;
  logic [15:0] x_reg;
  logic [15:0] y_reg;
  logic [1:0]  pat_reg;
  logic [7:0]  fc_lat_reg;
  logic        vsync_reg;
  logic        hsync_reg;
  logic [7:0]  pixdata_reg;
  logic [15:0] frame_count_reg;
  logic        frame_done_reg;
  logic        busy_reg;

  logic [15:0] slot_len_last;
  logic        slot_edge;
  logic        slot_last;

  // Pixel value for coordinate (px, py) under the latched pattern.
  function automatic logic [7:0] pix_val(input logic [1:0] p, input logic [15:0] px,
                                         input logic [15:0] py, input logic [7:0] fc);
    logic [15:0] sum;
    sum = px + py;
    case (p)
      2'd0:    return px[7:0];
      2'd1:    return fc;
      2'd2:    return (px[3] ^ py[3]) ? 8'hFF : 8'h00;
      default: return sum[7:0];
    endcase
  endfunction

  // Everything advances on the pixclk falling edge so data is stable
  // across the receiver's rising-edge sample.
  assign slot_edge = (div_reg == DIV_LAST) && pixclk_reg;
  assign slot_last = (slot_cnt_reg == slot_len_last);

  always_comb begin
    slot_len_last = 16'd0;
    case (state_reg)
      S_LEAD:   slot_len_last = LD_LAST;
      S_LINE:   slot_len_last = H_LAST;
      S_HBLANK: slot_len_last = HB_LAST;
      S_TAIL:   slot_len_last = TL_LAST;
      S_GAP:    slot_len_last = GP_LAST;
      default:  slot_len_last = 16'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      div_reg         <= '0;
      pixclk_reg      <= 1'b0;
      slot_cnt_reg    <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      pat_reg         <= '0;
      fc_lat_reg      <= '0;
      vsync_reg       <= 1'b0;
      hsync_reg       <= 1'b0;
      pixdata_reg     <= '0;
      frame_count_reg <= '0;
      frame_done_reg  <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;

      if (div_reg == DIV_LAST) begin
        div_reg    <= '0;
        pixclk_reg <= ~pixclk_reg;
      end else begin
        div_reg <= div_reg + 16'd1;
      end

      if (slot_edge) begin
        // Counter returns to zero on its last slot, which is exactly the
        // cycle a state change happens, so every state entry starts at 0.
        slot_cnt_reg <= slot_last ? 16'd0 : slot_cnt_reg + 16'd1;

        case (state_reg)
          S_IDLE: begin
            if (enable) begin
              state_reg  <= S_LEAD;
              vsync_reg  <= 1'b1;
              hsync_reg  <= 1'b0;
              busy_reg   <= 1'b1;
              pat_reg    <= pattern;
              fc_lat_reg <= frame_count_reg[7:0];
              y_reg      <= '0;
            end
          end

          S_LEAD: begin
            if (slot_last) begin
              state_reg   <= S_LINE;
              hsync_reg   <= 1'b1;
              x_reg       <= '0;
              pixdata_reg <= pix_val(pat_reg, 16'd0, y_reg, fc_lat_reg);
            end
          end

          S_LINE: begin
            if (slot_last) begin
              hsync_reg   <= 1'b0;
              pixdata_reg <= '0;
              state_reg   <= (y_reg == V_LAST) ? S_TAIL : S_HBLANK;
            end else begin
              x_reg       <= x_reg + 16'd1;
              pixdata_reg <= pix_val(pat_reg, x_reg + 16'd1, y_reg, fc_lat_reg);
            end
          end

          S_HBLANK: begin
            if (slot_last) begin
              state_reg   <= S_LINE;
              hsync_reg   <= 1'b1;
              y_reg       <= y_reg + 16'd1;
              x_reg       <= '0;
              pixdata_reg <= pix_val(pat_reg, 16'd0, y_reg + 16'd1, fc_lat_reg);
            end
          end

          S_TAIL: begin
            if (slot_last) begin
              state_reg       <= S_GAP;
              vsync_reg       <= 1'b0;
              frame_count_reg <= frame_count_reg + 16'd1;
              frame_done_reg  <= 1'b1;
            end
          end

          S_GAP: begin
            if (slot_last) begin
              if (enable) begin
                // frame_count has already been bumped for the frame just
                // finished, so pattern 1 shows the new frame's index.
                state_reg  <= S_LEAD;
                vsync_reg  <= 1'b1;
                pat_reg    <= pattern;
                fc_lat_reg <= frame_count_reg[7:0];
                y_reg      <= '0;
              end else begin
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
              end
            end
          end

          default: begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pixclk  = pixclk_reg;
  assign bus.vsync   = vsync_reg;
  assign bus.hsync   = hsync_reg;
  assign bus.pixdata = pixdata_reg;
  assign frame_count = frame_count_reg;
  assign frame_done  = frame_done_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_hm01b0_pixel_source.sv
module tb_hm01b0_pixel_source;

  logic        clk = 1'b0;
  logic        reset_a, reset_b;
  logic        enable_a, enable_b;
  logic [1:0]  pattern_a, pattern_b;
  logic [15:0] fc_a, fc_b;
  logic        fd_a, fd_b, busy_a, busy_b;

  hm01b0_pixel_source_if bus_a();
  hm01b0_pixel_source_if bus_b();

  // Small frame, CLK_DIV=1: 27 slots per frame, 54 clk.
  hm01b0_pixel_source #(.H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(3), .V_LEAD(2),
                        .V_TAIL(2), .F_GAP(5), .CLK_DIV(1)) dut_a (
    .clk(clk), .reset(reset_a), .enable(enable_a), .pattern(pattern_a),
    .bus(bus_a), .frame_count(fc_a), .frame_done(fd_a), .busy(busy_a));

  // Wider frame so the checker pattern toggles; CLK_DIV=3.
  hm01b0_pixel_source #(.H_ACTIVE(20), .V_ACTIVE(10), .H_BLANK(3), .V_LEAD(2),
                        .V_TAIL(2), .F_GAP(5), .CLK_DIV(3)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .pattern(pattern_b),
    .bus(bus_b), .frame_count(fc_b), .frame_done(fd_b), .busy(busy_b));

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int fd_time_a[$];
  int hs_cnt_a = 0, fd_cnt_a = 0, hs_cnt_b = 0, fd_cnt_b = 0;
  int pc_gap_a = 0, pc_gap_b = 0, pc_last_a = 0, pc_last_b = 0;
  logic pc_prev_a = 1'b0, hs_prev_a = 1'b0, pc_prev_b = 1'b0, hs_prev_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- monitors (scoreboard pop side) ----------------
  always @(negedge clk) begin
    if (bus_a.pixclk && !pc_prev_a) begin
      pc_gap_a  = cyc - pc_last_a;
      pc_last_a = cyc;
      if (bus_a.vsync && bus_a.hsync) begin
        if (exp_a.size() == 0) chk("pix_extra_a", bus_a.pixdata, 16'hDEAD);
        else begin
          logic [7:0] e;
          e = exp_a.pop_front();
          chk("pix_a", bus_a.pixdata, e);
          $display("A pixel %02h expected %02h", bus_a.pixdata, e);
        end
      end else begin
        chk("blank_a", bus_a.pixdata, 0);
      end
    end
    if (bus_a.hsync && !hs_prev_a) hs_cnt_a++;
    if (fd_a) begin
      fd_cnt_a++;
      fd_time_a.push_back(cyc);
    end
    pc_prev_a = bus_a.pixclk;
    hs_prev_a = bus_a.hsync;
  end

  always @(negedge clk) begin
    if (bus_b.pixclk && !pc_prev_b) begin
      pc_gap_b  = cyc - pc_last_b;
      pc_last_b = cyc;
      if (bus_b.vsync && bus_b.hsync) begin
        if (exp_b.size() == 0) chk("pix_extra_b", bus_b.pixdata, 16'hDEAD);
        else begin
          logic [7:0] e;
          e = exp_b.pop_front();
          chk("pix_b", bus_b.pixdata, e);
          $display("B pixel %02h expected %02h", bus_b.pixdata, e);
        end
      end else begin
        chk("blank_b", bus_b.pixdata, 0);
      end
    end
    if (bus_b.hsync && !hs_prev_b) hs_cnt_b++;
    if (fd_b) fd_cnt_b++;
    pc_prev_b = bus_b.pixclk;
    hs_prev_b = bus_b.hsync;
  end

  // ---------------- stimulus helpers (scoreboard push side) ----------------
  function automatic logic [7:0] model_pix(input int pat, input int x, input int y, input int fc);
    case (pat)
      0:       return 8'(x);
      1:       return 8'(fc);
      2:       return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
      default: return 8'(x + y);
    endcase
  endfunction

  task automatic push_frame(input int which, input int pat, input int fc);
    int w, h;
    w = which ? 20 : 4;
    h = which ? 10 : 3;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        if (which != 0) exp_b.push_back(model_pix(pat, x, y, fc));
        else            exp_a.push_back(model_pix(pat, x, y, fc));
  endtask

  // Hand-written ramp frame for the small DUT: each line 00,01,02,03.
  task automatic push_ramp_a();
    logic [7:0] line_vals [4];
    line_vals = '{8'h00, 8'h01, 8'h02, 8'h03};
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) exp_a.push_back(line_vals[x]);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int get_fd(input int which);
    return which ? fd_cnt_b : fd_cnt_a;
  endfunction

  function automatic int get_hs(input int which);
    return which ? hs_cnt_b : hs_cnt_a;
  endfunction

  task automatic wait_fd(input int which, input int target);
    for (int i = 0; i < 5000 && get_fd(which) < target; i++) step(1);
    chk(which ? "frame_done_wait_b" : "frame_done_wait_a", get_fd(which) >= target, 1);
  endtask

  task automatic wait_hs(input int which, input int target);
    for (int i = 0; i < 5000 && get_hs(which) < target; i++) step(1);
    chk(which ? "hsync_wait_b" : "hsync_wait_a", get_hs(which) >= target, 1);
  endtask

  task automatic wait_idle(input int which);
    for (int i = 0; i < 5000 && (which ? busy_b : busy_a); i++) step(1);
    chk(which ? "idle_wait_b" : "idle_wait_a", which ? busy_b : busy_a, 0);
  endtask

  task automatic wait_vsync(input int which);
    for (int i = 0; i < 5000 && !(which ? bus_b.vsync : bus_a.vsync); i++) step(1);
    chk(which ? "vsync_wait_b" : "vsync_wait_a", which ? bus_b.vsync : bus_a.vsync, 1);
  endtask

  // ---------------- sequence ----------------
  initial begin
    int lat, base_hs, base_fd;
    reset_a = 1'b0; reset_b = 1'b0;
    enable_a = 1'b0; enable_b = 1'b0;
    pattern_a = 2'd0; pattern_b = 2'd0;
    step(3);

    // Reset state
    chk("rst_pixclk", bus_a.pixclk, 0);
    chk("rst_vsync", bus_a.vsync, 0);
    chk("rst_hsync", bus_a.hsync, 0);
    chk("rst_pixdata", bus_a.pixdata, 0);
    chk("rst_frame_count", fc_a, 0);
    chk("rst_frame_done", fd_a, 0);
    chk("rst_busy", busy_a, 0);
    reset_a = 1'b1; reset_b = 1'b1;
    step(6);
    chk("idle_vsync", bus_a.vsync, 0);
    chk("idle_busy", busy_a, 0);

    // Pattern 1 over three frames: 00, 01, 02
    pattern_a = 2'd1;
    push_frame(0, 1, 0);
    push_frame(0, 1, 1);
    push_frame(0, 1, 2);
    base_hs = hs_cnt_a;
    enable_a = 1'b1;
    lat = 0;
    while (lat < 10 && !bus_a.vsync) begin
      step(1);
      lat++;
    end
    chk("enable_latency_le2", lat <= 2, 1);
    wait_fd(0, 3);
    enable_a = 1'b0;
    chk("frame_count_3", fc_a, 3);
    chk("frame_done_pulses_3", fd_cnt_a, 3);
    chk("hsync_pulses_9", hs_cnt_a - base_hs, 9);
    if (fd_time_a.size() >= 3) chk("frame_period_54", fd_time_a[2] - fd_time_a[1], 54);
    else chk("frame_period_samples", fd_time_a.size(), 3);
    wait_idle(0);
    chk("idle_after_p1_vsync", bus_a.vsync, 0);
    chk("queue_empty_p1", exp_a.size(), 0);
    chk("pixclk_period_2", pc_gap_a, 2);
    $display("A pattern1 run: frame_count=%0d", fc_a);

    // Ramp frame, enable dropped during line 2: frame must still complete
    pattern_a = 2'd0;
    push_ramp_a();
    base_hs = hs_cnt_a;
    base_fd = fd_cnt_a;
    enable_a = 1'b1;
    wait_hs(0, base_hs + 2);
    enable_a = 1'b0;
    wait_fd(0, base_fd + 1);
    chk("frame_count_4", fc_a, 4);
    wait_idle(0);
    chk("stop_vsync", bus_a.vsync, 0);
    chk("stop_busy", busy_a, 0);
    chk("queue_empty_ramp", exp_a.size(), 0);
    chk("hsync_pulses_ramp", hs_cnt_a - base_hs, 3);
    $display("A ramp/stop run: frame_count=%0d", fc_a);

    // Reset mid-line, then a fresh frame from LEAD
    push_ramp_a();
    base_hs = hs_cnt_a;
    enable_a = 1'b1;
    wait_hs(0, base_hs + 1);
    step(2);
    chk("midline_hsync", bus_a.hsync, 1);
    reset_a = 1'b0;
    step(1);
    chk("mrst_pixclk", bus_a.pixclk, 0);
    chk("mrst_vsync", bus_a.vsync, 0);
    chk("mrst_hsync", bus_a.hsync, 0);
    chk("mrst_pixdata", bus_a.pixdata, 0);
    chk("mrst_frame_count", fc_a, 0);
    chk("mrst_busy", busy_a, 0);
    exp_a.delete();
    push_ramp_a();
    base_fd = fd_cnt_a;
    reset_a = 1'b1;
    wait_vsync(0);
    chk("restart_in_lead_hsync", bus_a.hsync, 0);
    enable_a = 1'b0;
    wait_fd(0, base_fd + 1);
    chk("frame_count_after_reset", fc_a, 1);
    wait_idle(0);
    chk("queue_empty_reset", exp_a.size(), 0);
    $display("A reset run: frame_count=%0d", fc_a);

    // Pattern 0 -> 2 mid-frame on the CLK_DIV=3 instance
    push_frame(1, 0, 0);
    push_frame(1, 2, 1);
    base_hs = hs_cnt_b;
    enable_b = 1'b1;
    wait_hs(1, base_hs + 3);
    pattern_b = 2'd2;
    wait_fd(1, 1);
    wait_vsync(1);
    enable_b = 1'b0;
    wait_fd(1, 2);
    wait_idle(1);
    chk("b_frame_count_2", fc_b, 2);
    chk("b_queue_empty", exp_b.size(), 0);
    chk("b_pixclk_period_6", pc_gap_b, 6);
    $display("B pattern change run: frame_count=%0d", fc_b);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
